pll_lock_reset_seq: RTL and testbench

PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

---
 rtl/pll_lock_reset_seq.sv | 116 +++++++++++
 tb/tb_pll_lock_reset_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// PLL lock / reset sequencer.
// Pulses the PLL reset, waits for a synchronised lock indication, demands an
// unbroken run of locked cycles, then releases the SDRAM-domain reset.
// Lock loss in RUN or a relock timeout restarts the appropriate part of the
// sequence; both events are tallied in saturating 8-bit counters.
module pll_lock_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned RELOCK_TIMEOUT     = 65535,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       ready,
  output logic [7:0] loss_count,
  output logic [7:0] retry_count
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Terminal counts: a phase lasting N cycles leaves on the edge where cnt == N-1.
  localparam logic [15:0] PLL_LAST    = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(RELOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  loss_q, loss_d;
  logic [7:0]  retry_q, retry_d;
  logic        sync1_q, locked_s_q;

  // Next-state, cycle counter and event counters from current state and locked_s.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    loss_d  = loss_q;
    retry_d = retry_q;
    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == PLL_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock wins over a coincident timeout, so no retry is charged.
        if (locked_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RESET;
          cnt_d   = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
      end
      STABLE: begin
        // Any unlocked cycle throws away the accumulated stable count.
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      default: begin
        state_d = PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters, synchroniser and outputs all register on the same edge,
  // outputs decoded from the next state so they track the state exactly.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= PLL_RESET;
      cnt_q      <= '0;
      loss_q     <= '0;
      retry_q    <= '0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      pll_rst    <= 1'b1;
      sdram_rst  <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_q     <= loss_d;
      retry_q    <= retry_d;
      sync1_q    <= locked_in;
      locked_s_q <= sync1_q;
      pll_rst    <= (state_d == PLL_RESET);
      sdram_rst  <= (state_d != RUN);
      ready      <= (state_d == RUN);
    end
  end

  assign loss_count  = loss_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed scenarios with literal expectations,
// then randomized lock/reset stimulus, all outputs compared every cycle
// against a phase/duration model.
module tb_pll_lock_reset_seq;

  localparam int P = 4;
  localparam int T = 20;
  localparam int L = 8;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked_in;
  logic       pll_rst, sdram_rst, ready;
  logic [7:0] loss_count, retry_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  pll_lock_reset_seq #(
    .PLL_RST_CYCLES(P), .RELOCK_TIMEOUT(T), .LOCK_STABLE_CYCLES(L)
  ) dut (
    .refclk(refclk), .rst(rst), .locked_in(locked_in),
    .pll_rst(pll_rst), .sdram_rst(sdram_rst), .ready(ready),
    .loss_count(loss_count), .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which phase we are in and how many cycles it has run.
  // Phases: 0 = PLL held in reset, 1 = waiting for lock, 2 = proving stability, 3 = running.
  int m_ph = 0, m_t = 0, m_loss = 0, m_retry = 0;
  bit m_h1 = 0, m_h2 = 0;  // locked_in as seen one and two edges ago

  always @(posedge refclk) begin
    bit ls;
    ls = m_h2;
    if (rst) begin
      m_ph = 0; m_t = 0; m_loss = 0; m_retry = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      case (m_ph)
        0: begin m_t++; if (m_t == P) begin m_ph = 1; m_t = 0; end end
        1: if (ls) begin m_ph = 2; m_t = 0; end
           else begin
             m_t++;
             if (m_t == T) begin m_ph = 0; m_t = 0; if (m_retry < 255) m_retry++; end
           end
        2: if (!ls) begin m_ph = 1; m_t = 0; end
           else begin m_t++; if (m_t == L) begin m_ph = 3; m_t = 0; end end
        default: if (!ls) begin m_ph = 1; m_t = 0; if (m_loss < 255) m_loss++; end
      endcase
      m_h2 = m_h1;
      m_h1 = locked_in;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge refclk) begin
    if (chk_en) begin
      chk("pll_rst",     pll_rst,     m_ph == 0);
      chk("sdram_rst",   sdram_rst,   m_ph != 3);
      chk("ready",       ready,       m_ph == 3);
      chk("loss_count",  loss_count,  m_loss);
      chk("retry_count", retry_count, m_retry);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Steps until ready reaches 'lvl'; returns steps taken (limit+1 on expiry).
  task automatic wait_ready(input logic lvl, input int limit, output int n);
    n = 0;
    while (ready !== lvl && n <= limit) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n, pll_hi, sd_lo;
    rst = 1'b1;
    locked_in = 1'b0;
    step(3);
    chk_en = 1;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sdram_rst", sdram_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_counts", {loss_count, retry_count}, 0);

    // Clean start: 4 reset cycles, 1 wait cycle, 8 stable cycles.
    rst = 1'b0;
    locked_in = 1'b1;
    n = 0; pll_hi = 0;
    while (!ready && n < 40) begin
      if (pll_rst) pll_hi++;
      step(1);
      n++;
    end
    chk("clean_pll_hi_cycles", pll_hi, 4);
    chk("clean_ready_latency", n, 13);
    chk("clean_sdram_rst", sdram_rst, 0);

    // Glitch after 5 stable cycles: full 8 stable cycles demanded afterwards.
    reset_pulse();
    locked_in = 1'b1;
    step(10);
    locked_in = 1'b0;
    step(1);
    locked_in = 1'b1;
    wait_ready(1'b1, 40, n);
    chk("glitch_ready_latency", n, 11);
    chk("glitch_loss", loss_count, 0);

    // Lock loss in RUN for 3 cycles.
    locked_in = 1'b0;
    step(2);
    chk("loss_ready_still_hi", ready, 1);
    step(1);
    chk("loss_ready_lo", ready, 0);
    chk("loss_sdram_rst", sdram_rst, 1);
    chk("loss_count_1", loss_count, 1);
    locked_in = 1'b1;
    wait_ready(1'b1, 40, n);
    chk("relock_latency", n, 11);

    // No lock: pll_rst re-pulses every 24 cycles.
    reset_pulse();
    locked_in = 1'b0;
    pll_hi = 0; sd_lo = 0;
    for (int i = 0; i < 3 * (P + T); i++) begin
      step(1);
      if (pll_rst) pll_hi++;
      if (!sdram_rst) sd_lo++;
    end
    chk("nolock_pll_hi_cycles", pll_hi, 12);
    chk("nolock_sdram_lo_cycles", sd_lo, 0);
    chk("nolock_retry_3", retry_count, 3);

    // Race: locked_s rises on the timeout cycle (edge 24 after release).
    reset_pulse();
    locked_in = 1'b0;
    step(21);
    locked_in = 1'b1;
    step(3);
    chk("race_pll_rst", pll_rst, 0);
    chk("race_retry", retry_count, 0);
    step(L);
    chk("race_ready", ready, 1);

    // Saturation: 300 lock losses from RUN.
    for (int i = 0; i < 300; i++) begin
      locked_in = 1'b0;
      step(1);
      locked_in = 1'b1;
      wait_ready(1'b0, 10, n);
      if (n > 10) chk("sat_drop_timeout", n, 10);
      wait_ready(1'b1, 40, n);
      if (n > 40) chk("sat_relock_timeout", n, 40);
    end
    chk("sat_loss_255", loss_count, 255);

    // Reset in RUN takes effect on the next edge.
    rst = 1'b1;
    step(1);
    chk("midrun_pll_rst", pll_rst, 1);
    chk("midrun_sdram_rst", sdram_rst, 1);
    chk("midrun_ready", ready, 0);
    chk("midrun_counts", {loss_count, retry_count}, 0);
    rst = 1'b0;

    // Randomized lock behaviour with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if (locked_in ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 24) == 0))
        locked_in = ~locked_in;
      rst = ($urandom_range(0, 599) == 0);
      step(1);
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
